pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Parametrised hazard/forwarding controller for the next-generation in-order pipeline. Tracks DEPTH in-flight
//  instructions after ID, drives per-source forwarding selects, load-use stalls, memory-wait freeze and
//  branch-redirect gating. Replaces the single-stage, load-unaware RD compare with a scoreboard of arbitrary depth.
// PARAMETERS
//  REG_ADDR_W  5  register address width
//  DEPTH       3  tracked stages after ID; stage DEPTH is writeback (regfile written at end of that cycle)
//  LOAD_LAT    1  extra stages before load data is forwardable; ALU results forwardable from stage 1
//  SEL_W       $clog2(DEPTH+1)  width of forwarding selects / in-flight count (derived, do not override)
// PORTS
//  clk          in   1           clock, rising edge
//  rst          in   1           asynchronous, active-low reset
//  id_valid     in   1           instruction present in ID
//  id_ra        in   REG_ADDR_W   source A address
//  id_ra_used   in   1           source A is read
//  id_rb        in   REG_ADDR_W   source B address
//  id_rb_used   in   1           source B is read
//  id_rd        in   REG_ADDR_W   destination address
//  id_we        in   1           instruction writes id_rd
//  id_is_load   in   1           instruction is a load
//  branch_taken in   1           branch unit resolved taken for the ID instruction
//  mem_stall    in   1           dmem wait; freezes the whole tracked pipeline
//  issue        out  1           ID instruction advances into stage 1 this cycle
//  id_stall     out  1           hold PC and IF/ID register
//  redirect_en  out  1           = branch_taken & issue; PC load and IF/ID flush
//  fwd_sel_a    out  SEL_W        0 = regfile, k = forward from stage k (1..DEPTH)
//  fwd_sel_b    out  SEL_W        as fwd_sel_a for source B
//  inflight_cnt out  SEL_W        number of valid tracked entries
// BEHAVIOUR
//  - Entry per stage k=1..DEPTH: {valid, rd, we, avail}; avail = 1 for ALU ops, 1+LOAD_LAT for loads.
//  - Advance (mem_stall=0): stage k -> k+1, stage DEPTH retires; stage 1 loads ID fields if issue, else bubble (valid=0).
//  - mem_stall=1: no entry moves; issue=0, id_stall=1, redirect_en=0; selects still computed combinationally.
//  - Source match: used & valid & we & rd==src; youngest (lowest k) match wins; no match -> select 0.
//  - Hazard: youngest match at stage k < avail -> hazard for that source (load-use). r0 not special-cased.
//  - id_stall = id_valid & (hazard_a | hazard_b | mem_stall); issue = id_valid & !id_stall.
//  - Load directly followed by consumer, LOAD_LAT=1: exactly one stall cycle, then forward from stage 2.
//  - Branch: redirect_en asserted only in the cycle the branch issues; taken branch under hazard waits.
//  - Branch issues as an entry with we=0 (occupies a slot, never matched).
//  - All outputs combinational from entries + inputs; zero latency. Selects are don't-care when the source is unused (driven 0).
//  - Reset (rst=0, any time, incl. mid-flight): all entries invalid immediately; issue, id_stall,
//    redirect_en, fwd_sel_a/b, inflight_cnt forced 0 while rst low.
//  - inflight_cnt updates one cycle after issue/retire; saturation impossible (max DEPTH).
// CONFIGURATION
//  HAZARD_FWD_EN defined: forwarding as above.
//  HAZARD_FWD_EN undefined: fwd_sel_a/b tied 0; any matching entry (any stage, any avail) is a hazard,
//    i.e. consumer stalls until producer has retired from stage DEPTH.
// STRUCTURE
//  pipeline_pkg: entry struct (valid, rd, we, avail), FWD_REGFILE=0 constant, SEL_W helper function.
//  Sub-module hazard_match: one source vs all entries -> {sel, hazard}; instantiated twice (A, B).
// TESTING  (DEPTH=3, LOAD_LAT=1, HAZARD_FWD_EN defined unless noted)
//  1 ADD r3 issues, next cycle SUB reads r3 as A -> issue=1, fwd_sel_a=1, id_stall=0.
//  2 LW r5 issues, next reads r5 as B -> one cycle id_stall=1/issue=0, then fwd_sel_b=2, issue=1.
//  3 ADD r7 then ORI r7, third reads r7 -> fwd_sel_a=1 (youngest), not 2.
//  4 LW r4, branch_taken reading r4 next -> redirect_en=0 first cycle, =1 second cycle.
//  5 3 entries valid, mem_stall=1 for 3 cycles -> inflight_cnt stays 3, issue=0, selects unchanged.
//  6 rst low mid-flight -> inflight_cnt=0, id_stall=0 immediately; after release no stale forwards.
//  7 macro undefined, ADD r3 then reader of r3 -> id_stall=1 for 3 cycles, issue 4th cycle with fwd_sel_a=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: tracked-entry payload and select sizing.
package pipeline_pkg;

    // Entry fields are sized for the widest supported configuration; narrower addresses are zero-extended.
    localparam int unsigned RD_MAX_W    = 8;
    localparam int unsigned AVAIL_W     = 4;
    localparam int unsigned FWD_REGFILE = 0;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                we;
        logic [AVAIL_W-1:0]  avail;
    } entry_t;

    function automatic int unsigned sel_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source register against every tracked entry; returns forwarding stage and hazard flag.
// HAZARD_FWD_EN selects forwarding; without it any matching in-flight producer is a hazard.
module hazard_match
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned SEL_W      = 2
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  used,
    input  entry_t                entries [1:DEPTH],
    output logic [SEL_W-1:0]      sel,
    output logic                  hazard
);

`ifdef HAZARD_FWD_EN
    // Scan oldest to youngest so the youngest match overrides.
    always_comb begin
        sel    = SEL_W'(FWD_REGFILE);
        hazard = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (used && entries[k].valid && entries[k].we &&
                (entries[k].rd == RD_MAX_W'(src))) begin
                sel    = SEL_W'(k);
                hazard = (32'(entries[k].avail) > 32'(k));
            end
        end
    end
`else
    logic unused_avail;

    always_comb begin
        sel          = SEL_W'(FWD_REGFILE);
        hazard       = 1'b0;
        unused_avail = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            unused_avail = unused_avail ^ (^entries[k].avail);
            if (used && entries[k].valid && entries[k].we &&
                (entries[k].rd == RD_MAX_W'(src))) begin
                hazard = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// In-order pipeline hazard controller: DEPTH-entry scoreboard, forwarding selects, load-use and memory stalls.
// Build with HAZARD_FWD_EN for forwarding; otherwise consumers wait for producers to retire.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter  int unsigned REG_ADDR_W = 5,
    parameter  int unsigned DEPTH      = 3,
    parameter  int unsigned LOAD_LAT   = 1,
    localparam int unsigned SEL_W      = sel_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_ra,
    input  logic                  id_ra_used,
    input  logic [REG_ADDR_W-1:0] id_rb,
    input  logic                  id_rb_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_we,
    input  logic                  id_is_load,
    input  logic                  branch_taken,
    input  logic                  mem_stall,
    output logic                  issue,
    output logic                  id_stall,
    output logic                  redirect_en,
    output logic [SEL_W-1:0]      fwd_sel_a,
    output logic [SEL_W-1:0]      fwd_sel_b,
    output logic [SEL_W-1:0]      inflight_cnt
);

    entry_t           entries [1:DEPTH];
    entry_t           id_entry;
    logic             hazard_a;
    logic             hazard_b;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic [SEL_W-1:0] cnt;
    logic             stall_raw;
    logic             issue_raw;

    hazard_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .DEPTH      (DEPTH),
        .SEL_W      (SEL_W)
    ) u_match_a (
        .src     (id_ra),
        .used    (id_ra_used),
        .entries (entries),
        .sel     (sel_a),
        .hazard  (hazard_a)
    );

    hazard_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .DEPTH      (DEPTH),
        .SEL_W      (SEL_W)
    ) u_match_b (
        .src     (id_rb),
        .used    (id_rb_used),
        .entries (entries),
        .sel     (sel_b),
        .hazard  (hazard_b)
    );

    // Entry built from the ID instruction; a taken branch never produces a forwardable result.
    always_comb begin
        id_entry       = '0;
        id_entry.valid = 1'b1;
        id_entry.rd    = RD_MAX_W'(id_rd);
        id_entry.we    = id_we & ~branch_taken;
        id_entry.avail = id_is_load ? AVAIL_W'(1 + LOAD_LAT) : AVAIL_W'(1);
    end

    always_comb begin
        stall_raw = id_valid & (hazard_a | hazard_b | mem_stall);
        issue_raw = id_valid & ~stall_raw;
    end

    // Shift the scoreboard unless memory freezes the pipeline; a non-issuing cycle inserts a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                entries[k] <= '0;
            end
        end else if (!mem_stall) begin
            entries[1] <= issue_raw ? id_entry : '0;
            for (int k = 2; k <= DEPTH; k++) begin
                entries[k] <= entries[k-1];
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            cnt = cnt + SEL_W'(entries[k].valid);
        end
    end

    // All outputs held at zero while reset is asserted.
    always_comb begin
        issue        = rst & issue_raw;
        id_stall     = rst & stall_raw;
        redirect_en  = rst & issue_raw & branch_taken;
        fwd_sel_a    = rst ? sel_a : '0;
        fwd_sel_b    = rst ? sel_b : '0;
        inflight_cnt = rst ? cnt : '0;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (DEPTH=3, LOAD_LAT=1); expectations follow HAZARD_FWD_EN.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [4:0] ra;
        logic       ua;
        logic [4:0] rb;
        logic       ub;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       br;
        logic       ms;
    } stim_t;

    // Observation order: issue, id_stall, redirect_en, fwd_sel_a, fwd_sel_b, inflight_cnt
    typedef struct packed {
        logic       issue;
        logic       stall;
        logic       redir;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] cnt;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_ra;
    logic       id_ra_used;
    logic [4:0] id_rb;
    logic       id_rb_used;
    logic [4:0] id_rd;
    logic       id_we;
    logic       id_is_load;
    logic       branch_taken;
    logic       mem_stall;
    logic       issue;
    logic       id_stall;
    logic       redirect_en;
    logic [1:0] fwd_sel_a;
    logic [1:0] fwd_sel_b;
    logic [1:0] inflight_cnt;

    obs_t exp_q [$];
    int   checks;
    int   failures;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (5),
        .DEPTH      (3),
        .LOAD_LAT   (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_ra        (id_ra),
        .id_ra_used   (id_ra_used),
        .id_rb        (id_rb),
        .id_rb_used   (id_rb_used),
        .id_rd        (id_rd),
        .id_we        (id_we),
        .id_is_load   (id_is_load),
        .branch_taken (branch_taken),
        .mem_stall    (mem_stall),
        .issue        (issue),
        .id_stall     (id_stall),
        .redirect_en  (redirect_en),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .inflight_cnt (inflight_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t ins(input logic [4:0] ra, input logic ua, input logic [4:0] rb,
                                  input logic ub, input logic [4:0] rd, input logic we,
                                  input logic ld, input logic br);
        stim_t s;
        s.rst = 1'b1; s.valid = 1'b1;
        s.ra = ra; s.ua = ua; s.rb = rb; s.ub = ub; s.rd = rd;
        s.we = we; s.ld = ld; s.br = br; s.ms = 1'b0;
        return s;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic obs_t o(input logic i, input logic st, input logic rd,
                               input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        obs_t r;
        r.issue = i; r.stall = st; r.redir = rd; r.sa = a; r.sb = b; r.cnt = c;
        return r;
    endfunction

    task automatic apply(input stim_t s);
        rst          = s.rst;
        id_valid     = s.valid;
        id_ra        = s.ra;
        id_ra_used   = s.ua;
        id_rb        = s.rb;
        id_rb_used   = s.ub;
        id_rd        = s.rd;
        id_we        = s.we;
        id_is_load   = s.ld;
        branch_taken = s.br;
        mem_stall    = s.ms;
    endtask

    task automatic drive(input stim_t s, input obs_t e);
        @(negedge clk);
        apply(s);
        exp_q.push_back(e);
    endtask

    task automatic drain();
        repeat (3) begin
            @(negedge clk);
            apply(idle());
        end
    endtask

    task automatic test_reset();
        stim_t st [2];
        obs_t  ex [2];
        obs_t  got;
        obs_t  exp;
        st[0] = ins(3, 1, 4, 1, 5, 1, 1, 1); st[0].rst = 1'b0; st[0].ms = 1'b1;
        st[1] = idle();
        ex[0] = o(0, 0, 0, 0, 0, 0);
        ex[1] = o(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            drive(st[i], ex[i]);
            #2;
            got = {issue, id_stall, redirect_en, fwd_sel_a, fwd_sel_b, inflight_cnt};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset step %0d: got=%b expected=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_alu_fwd();
        stim_t st [5];
        obs_t  ex [5];
        obs_t  got;
        obs_t  exp;
        int    n;
        st[0] = ins(1, 1, 2, 1, 3, 1, 0, 0);
        for (int i = 1; i < 5; i++) st[i] = ins(3, 1, 1, 1, 6, 1, 0, 0);
        ex[0] = o(1, 0, 0, 0, 0, 0);
        if (FWD) begin
            n = 2;
            ex[1] = o(1, 0, 0, 1, 0, 1);
        end else begin
            n = 5;
            for (int i = 1; i < 4; i++) ex[i] = o(0, 1, 0, 0, 0, 1);
            ex[4] = o(1, 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < n; i++) begin
            drive(st[i], ex[i]);
            #2;
            got = {issue, id_stall, redirect_en, fwd_sel_a, fwd_sel_b, inflight_cnt};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL alu_fwd step %0d: got=%b expected=%b", i, got, exp);
            end
        end
        drain();
    endtask

    task automatic test_load_use();
        stim_t st [5];
        obs_t  ex [5];
        obs_t  got;
        obs_t  exp;
        int    n;
        st[0] = ins(1, 1, 0, 0, 5, 1, 1, 0);
        for (int i = 1; i < 5; i++) st[i] = ins(2, 1, 5, 1, 8, 1, 0, 0);
        ex[0] = o(1, 0, 0, 0, 0, 0);
        if (FWD) begin
            n = 3;
            ex[1] = o(0, 1, 0, 0, 1, 1);
            ex[2] = o(1, 0, 0, 0, 2, 1);
        end else begin
            n = 5;
            for (int i = 1; i < 4; i++) ex[i] = o(0, 1, 0, 0, 0, 1);
            ex[4] = o(1, 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < n; i++) begin
            drive(st[i], ex[i]);
            #2;
            got = {issue, id_stall, redirect_en, fwd_sel_a, fwd_sel_b, inflight_cnt};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL load_use step %0d: got=%b expected=%b", i, got, exp);
            end
        end
        drain();
    endtask

    task automatic test_youngest();
        stim_t st [6];
        obs_t  ex [6];
        obs_t  got;
        obs_t  exp;
        int    n;
        st[0] = ins(1, 1, 2, 1, 7, 1, 0, 0);
        st[1] = ins(1, 1, 0, 0, 7, 1, 0, 0);
        for (int i = 2; i < 6; i++) st[i] = ins(7, 1, 0, 0, 9, 1, 0, 0);
        ex[0] = o(1, 0, 0, 0, 0, 0);
        ex[1] = o(1, 0, 0, 0, 0, 1);
        if (FWD) begin
            n = 3;
            ex[2] = o(1, 0, 0, 1, 0, 2);
        end else begin
            n = 6;
            ex[2] = o(0, 1, 0, 0, 0, 2);
            ex[3] = o(0, 1, 0, 0, 0, 2);
            ex[4] = o(0, 1, 0, 0, 0, 1);
            ex[5] = o(1, 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < n; i++) begin
            drive(st[i], ex[i]);
            #2;
            got = {issue, id_stall, redirect_en, fwd_sel_a, fwd_sel_b, inflight_cnt};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL youngest step %0d: got=%b expected=%b", i, got, exp);
            end
        end
        drain();
    endtask

    task automatic test_branch();
        stim_t st [6];
        obs_t  ex [6];
        obs_t  got;
        obs_t  exp;
        int    n;
        st[0] = ins(1, 1, 0, 0, 4, 1, 1, 0);
        ex[0] = o(1, 0, 0, 0, 0, 0);
        if (FWD) begin
            n = 4;
            st[1] = ins(4, 1, 0, 0, 0, 0, 0, 1);
            st[2] = st[1];
            st[3] = ins(0, 1, 4, 1, 15, 1, 0, 0);
            ex[1] = o(0, 1, 0, 1, 0, 1);
            ex[2] = o(1, 0, 1, 2, 0, 1);
            ex[3] = o(1, 0, 0, 0, 3, 2);
        end else begin
            n = 6;
            for (int i = 1; i < 5; i++) st[i] = ins(4, 1, 0, 0, 0, 0, 0, 1);
            st[5] = ins(0, 1, 4, 1, 15, 1, 0, 0);
            for (int i = 1; i < 4; i++) ex[i] = o(0, 1, 0, 0, 0, 1);
            ex[4] = o(1, 0, 1, 0, 0, 0);
            ex[5] = o(1, 0, 0, 0, 0, 1);
        end
        for (int i = 0; i < n; i++) begin
            drive(st[i], ex[i]);
            #2;
            got = {issue, id_stall, redirect_en, fwd_sel_a, fwd_sel_b, inflight_cnt};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL branch step %0d: got=%b expected=%b", i, got, exp);
            end
        end
        drain();
    endtask

    task automatic test_mem_stall();
        stim_t st [10];
        obs_t  ex [10];
        obs_t  got;
        obs_t  exp;
        stim_t w;
        int    n;
        st[0] = ins(1, 1, 2, 1, 10, 1, 0, 0);
        st[1] = ins(1, 1, 2, 1, 11, 1, 0, 0);
        st[2] = ins(1, 1, 2, 1, 12, 1, 0, 0);
        w = ins(12, 1, 10, 1, 0, 0, 0, 1);
        w.ms = 1'b1;
        for (int i = 3; i < 6; i++) st[i] = w;
        w.ms = 1'b0;
        for (int i = 6; i < 10; i++) st[i] = w;
        ex[0] = o(1, 0, 0, 0, 0, 0);
        ex[1] = o(1, 0, 0, 0, 0, 1);
        ex[2] = o(1, 0, 0, 0, 0, 2);
        if (FWD) begin
            n = 7;
            for (int i = 3; i < 6; i++) ex[i] = o(0, 1, 0, 1, 3, 3);
            ex[6] = o(1, 0, 1, 1, 3, 3);
        end else begin
            n = 10;
            for (int i = 3; i < 7; i++) ex[i] = o(0, 1, 0, 0, 0, 3);
            ex[7] = o(0, 1, 0, 0, 0, 2);
            ex[8] = o(0, 1, 0, 0, 0, 1);
            ex[9] = o(1, 0, 1, 0, 0, 0);
        end
        for (int i = 0; i < n; i++) begin
            drive(st[i], ex[i]);
            #2;
            got = {issue, id_stall, redirect_en, fwd_sel_a, fwd_sel_b, inflight_cnt};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL mem_stall step %0d: got=%b expected=%b", i, got, exp);
            end
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        stim_t st [4];
        obs_t  ex [4];
        obs_t  got;
        obs_t  exp;
        st[0] = ins(1, 1, 2, 1, 13, 1, 0, 0);
        st[1] = ins(1, 1, 2, 1, 14, 1, 0, 0);
        st[2] = ins(13, 1, 14, 1, 0, 1, 0, 1);
        st[2].rst = 1'b0;
        st[3] = ins(13, 1, 14, 1, 16, 1, 0, 0);
        ex[0] = o(1, 0, 0, 0, 0, 0);
        ex[1] = o(1, 0, 0, 0, 0, 1);
        ex[2] = o(0, 0, 0, 0, 0, 0);
        ex[3] = o(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(st[i], ex[i]);
            #2;
            got = {issue, id_stall, redirect_en, fwd_sel_a, fwd_sel_b, inflight_cnt};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_midflight step %0d: got=%b expected=%b", i, got, exp);
            end
        end
        drain();
    endtask

    initial begin
        stim_t s0;
        checks   = 0;
        failures = 0;
        s0 = idle();
        s0.rst = 1'b0;
        apply(s0);
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_youngest();
        test_branch();
        test_mem_stall();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
